seg7_scan_decoder: RTL and testbench

//  Receive side of the seven-segment display interface: samples an external multiplexed
//  7-seg bus (segment lines + digit enables) and recovers the hex nibble shown on each digit.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_scan_decoder_if.sv | 39 +++
 rtl/seg7_pattern_decode.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment readback logic.
//   SEG_W     segment line count (a..g)
//   NIB_W     decoded nibble width
//   SEG_TABLE active-high gfedcba pattern for each hex nibble 0..F
//   state_e   scan-decoder FSM states
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // Index is the nibble value; entry is the pattern an encoder drives for it.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    StWait,
    StSettle,
    StCapture,
    StHold
  } state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: bus between the GPIO-facing stimulus side and the scan decoder.
//   seg_in      segment lines as seen on the header (raw polarity)
//   dig_en      digit enables as seen on the header (raw polarity)
//   value       decoded nibbles, digit i at [4i+3:4i]
//   digit_valid digit i holds a legal decode captured since reset
//   digit_err   last stable pattern on digit i was not a hex glyph
//   frame_done  one-cycle pulse when every digit has been captured
//   err_count   illegal-capture counter, present only with SEG7_DECODE_ERR_CNT_EN
// master drives the header lines; slave is the decoder.
interface seg7_scan_decoder_if #(
  parameter int unsigned DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_en;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_valid;
  logic [DIGITS-1:0]   digit_err;
  logic                frame_done;
`ifdef SEG7_DECODE_ERR_CNT_EN
  logic [7:0]          err_count;
`endif

  modport master (
    output seg_in, dig_en,
`ifdef SEG7_DECODE_ERR_CNT_EN
    input  err_count,
`endif
    input  value, digit_valid, digit_err, frame_done
  );

  modport slave (
    input  seg_in, dig_en,
`ifdef SEG7_DECODE_ERR_CNT_EN
    output err_count,
`endif
    output value, digit_valid, digit_err, frame_done
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational inverse of a nibble->segment encoder.
//   pattern  in  7  active-high gfedcba pattern
//   legal    out 1  pattern is one of the 16 hex glyphs
//   nibble   out 4  decoded value (0 when illegal)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic             legal,
  output logic [NIB_W-1:0] nibble
);

  // Table entries are distinct, so at most one index can match.
  always_comb begin
    legal  = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        legal  = 1'b1;
        nibble = NIB_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed seven-segment bus and recovers the hex nibble
// shown on each digit.
//   CLOCK_50  system clock
//   RESET     asynchronous active-high reset
//   bus       seg7_scan_decoder_if.slave (seg_in/dig_en in; value, digit_valid,
//             digit_err, frame_done out)
// Parameters: DIGITS (1..8), STABLE_CYCLES (>=2) identical samples before capture,
// ACTIVE_LOW selects inverted header polarity.
// Optional feature: define SEG7_DECODE_ERR_CNT_EN to add bus.err_count, a saturating
// count of illegal captures cleared only by RESET.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input logic              CLOCK_50,
  input logic              RESET,
  seg7_scan_decoder_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  // Raw level of an inactive line; also the XOR mask that normalizes to active-high.
  localparam logic [SEG_W-1:0]  SegIdle = {SEG_W{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DigIdle = {DIGITS{ACTIVE_LOW}};

  logic [SEG_W-1:0]    seg_s1, seg_s2, seg_n;
  logic [DIGITS-1:0]   dig_s1, dig_s2, dig_n;
  logic                dig_onehot, changed;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SEG_W-1:0]    pat_q, pat_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                frame_q, frame_d;
`ifdef SEG7_DECODE_ERR_CNT_EN
  logic [7:0]          err_cnt_q, err_cnt_d;
`endif

  logic                dec_legal;
  logic [NIB_W-1:0]    dec_nibble;

  seg7_pattern_decode u_decode (
    .pattern (pat_q),
    .legal   (dec_legal),
    .nibble  (dec_nibble)
  );

  always_comb begin
    seg_n      = seg_s2 ^ SegIdle;
    dig_n      = dig_s2 ^ DigIdle;
    dig_onehot = (dig_n != '0) && ((dig_n & (dig_n - DIGITS'(1))) == '0);
    changed    = (seg_n != pat_q) || (dig_n != dig_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dig_d   = dig_q;
    mask_d  = mask_q;
    value_d = value_q;
    valid_d = valid_q;
    err_d   = err_q;
    frame_d = 1'b0;
`ifdef SEG7_DECODE_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
`endif

    // A full mask is reported one cycle after it fills, and cleared at the same edge.
    if (mask_q == '1) begin
      frame_d = 1'b1;
      mask_d  = '0;
    end

    unique case (state_q)
      StWait: begin
        if (dig_onehot) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
          pat_d   = seg_n;
          dig_d   = dig_n;
        end
      end

      StSettle: begin
        if (!dig_onehot) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = CntW'(1);
          pat_d = seg_n;
          dig_d = dig_n;
        end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
          // This sample is the STABLE_CYCLES-th identical one.
          cnt_d   = CntW'(STABLE_CYCLES);
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StCapture: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_q[i]) begin
            if (dec_legal) begin
              value_d[4*i +: 4] = dec_nibble;
              valid_d[i]        = 1'b1;
              err_d[i]          = 1'b0;
            end else begin
              err_d[i] = 1'b1;
            end
          end
        end
        mask_d = mask_d | dig_q;
`ifdef SEG7_DECODE_ERR_CNT_EN
        if (!dec_legal && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
        // The sample arriving this cycle is not dropped: a change starts the next
        // settle window here, so every enable interval gets its full sample count.
        if (!dig_onehot) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (changed) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
          pat_d   = seg_n;
          dig_d   = dig_n;
        end else begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end

      StHold: begin
        if (!dig_onehot) begin
          state_d = StWait;
        end else if (changed) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
          pat_d   = seg_n;
          dig_d   = dig_n;
        end
      end

      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      seg_s1    <= SegIdle;
      seg_s2    <= SegIdle;
      dig_s1    <= DigIdle;
      dig_s2    <= DigIdle;
      state_q   <= StWait;
      cnt_q     <= '0;
      pat_q     <= '0;
      dig_q     <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      frame_q   <= 1'b0;
`ifdef SEG7_DECODE_ERR_CNT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      seg_s1    <= bus.seg_in;
      seg_s2    <= seg_s1;
      dig_s1    <= bus.dig_en;
      dig_s2    <= dig_s1;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      dig_q     <= dig_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      frame_q   <= frame_d;
`ifdef SEG7_DECODE_ERR_CNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_err   = err_q;
  assign bus.frame_done  = frame_q;
`ifdef SEG7_DECODE_ERR_CNT_EN
  assign bus.err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=8, active-low header lines).
// Stimulus is a list of (pattern, digit, duration) segments; the reference model reasons
// per segment: a one-hot segment lasting at least STABLE_CYCLES samples is captured once.
module tb_seg7_scan_decoder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned S      = 8;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_decoder #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (S),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model state.
  logic [15:0] m_value;
  logic [3:0]  m_valid, m_err, m_mask;
  int          m_frames, m_errcnt;
  int          frames_seen = 0;

  always @(negedge clk) if (bus.frame_done === 1'b1) frames_seen++;

  function automatic bit is_onehot(input logic [3:0] d);
    return (d != 4'h0) && ((d & (d - 4'h1)) == 4'h0);
  endfunction

  task automatic model_reset();
    m_value = '0; m_valid = '0; m_err = '0; m_mask = '0; m_errcnt = 0;
  endtask

  task automatic model_segment(input logic [6:0] pat, input logic [3:0] dig, input int len);
    bit         legal;
    logic [3:0] nib;
    legal = 1'b0;
    nib   = '0;
    if (!is_onehot(dig) || len < int'(S)) return;
    for (int k = 0; k < 16; k++) if (glyph[k] == pat) begin legal = 1'b1; nib = 4'(k); end
    for (int i = 0; i < 4; i++) begin
      if (dig[i]) begin
        if (legal) begin m_value[4*i +: 4] = nib; m_valid[i] = 1'b1; m_err[i] = 1'b0; end
        else m_err[i] = 1'b1;
      end
    end
    if (!legal && m_errcnt < 255) m_errcnt++;
    m_mask = m_mask | dig;
    if (m_mask == 4'hF) begin m_frames++; m_mask = '0; end
  endtask

  // Drive an active-high (pattern, digit) for len cycles onto the active-low header.
  task automatic play(input logic [6:0] pat, input logic [3:0] dig, input int len);
    bus.seg_in = ~pat;
    bus.dig_en = ~dig;
    model_segment(pat, dig, len);
    repeat (len) @(negedge clk);
  endtask

  task automatic flush();
    play(7'h00, 4'h0, S + 6);
  endtask

  task automatic test_reset();
    checks++; if (bus.value !== 16'h0) begin failures++;
      $display("FAIL reset_value got=%h want=0000", bus.value); end
    checks++; if (bus.digit_valid !== 4'h0) begin failures++;
      $display("FAIL reset_valid got=%b want=0000", bus.digit_valid); end
    checks++; if (bus.digit_err !== 4'h0) begin failures++;
      $display("FAIL reset_err got=%b want=0000", bus.digit_err); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++;
      $display("FAIL reset_frame got=%b want=0", bus.frame_done); end
`ifdef SEG7_DECODE_ERR_CNT_EN
    checks++; if (bus.err_count !== 8'd0) begin failures++;
      $display("FAIL reset_errcnt got=%0d want=0", bus.err_count); end
`endif
  endtask

  // Value must appear exactly 2 + S + 1 edges after the new pattern is presented.
  task automatic test_latency();
    bus.seg_in = ~7'h06;
    bus.dig_en = ~4'b0001;
    model_segment(7'h06, 4'b0001, S + 4);
    repeat (S + 2) @(negedge clk);
    checks++; if (bus.digit_valid[0] !== 1'b0) begin failures++;
      $display("FAIL latency_early got=%b want=0", bus.digit_valid[0]); end
    @(negedge clk);
    checks++; if (bus.digit_valid[0] !== 1'b1) begin failures++;
      $display("FAIL latency_valid got=%b want=1", bus.digit_valid[0]); end
    checks++; if (bus.value[3:0] !== 4'h1) begin failures++;
      $display("FAIL latency_value got=%h want=1", bus.value[3:0]); end
    @(negedge clk);
    flush();
  endtask

  task automatic test_scan();
    int f0;
    f0 = frames_seen;
    play(7'h6D, 4'b0001, S + 4);
    play(7'h77, 4'b0010, S + 4);
    play(7'h5E, 4'b0100, S + 4);
    play(7'h71, 4'b1000, S + 4);
    flush();
    checks++; if (bus.value !== 16'hFDA5) begin failures++;
      $display("FAIL scan_value got=%h want=FDA5", bus.value); end
    checks++; if (bus.digit_valid !== 4'hF) begin failures++;
      $display("FAIL scan_valid got=%b want=1111", bus.digit_valid); end
    checks++; if (frames_seen - f0 !== 1) begin failures++;
      $display("FAIL scan_frame got=%0d want=1", frames_seen - f0); end
  endtask

  task automatic test_toggle();
    for (int r = 0; r < 6; r++) play((r % 2 == 0) ? 7'h3F : 7'h06, 4'b0010, S - 1);
    flush();
    checks++; if (bus.value !== 16'hFDA5) begin failures++;
      $display("FAIL toggle_value got=%h want=FDA5", bus.value); end
    checks++; if (bus.digit_err !== 4'h0) begin failures++;
      $display("FAIL toggle_err got=%b want=0000", bus.digit_err); end
  endtask

  task automatic test_blank();
    int e0;
    e0 = m_errcnt;
    play(7'h00, 4'b0100, S + 4);
    flush();
    checks++; if (bus.digit_err[2] !== 1'b1) begin failures++;
      $display("FAIL blank_err got=%b want=1", bus.digit_err[2]); end
    checks++; if (bus.digit_valid[2] !== 1'b1) begin failures++;
      $display("FAIL blank_valid got=%b want=1", bus.digit_valid[2]); end
    checks++; if (bus.value[11:8] !== 4'hD) begin failures++;
      $display("FAIL blank_value got=%h want=d", bus.value[11:8]); end
`ifdef SEG7_DECODE_ERR_CNT_EN
    checks++; if (int'(bus.err_count) !== e0 + 1) begin failures++;
      $display("FAIL blank_errcnt got=%0d want=%0d", bus.err_count, e0 + 1); end
`else
    if (e0 < 0) $display("unreachable");
`endif
  endtask

  task automatic test_multi();
    play(7'h4F, 4'b0011, 3 * S);
    checks++; if (bus.value !== m_value || bus.digit_err !== m_err) begin failures++;
      $display("FAIL multi_hold got=%h/%b want=%h/%b", bus.value, bus.digit_err, m_value, m_err);
    end
    play(7'h07, 4'b0100, S + 4);
    flush();
    checks++; if (bus.value[11:8] !== 4'h7) begin failures++;
      $display("FAIL multi_value got=%h want=7", bus.value[11:8]); end
    checks++; if (bus.digit_err[2] !== 1'b0) begin failures++;
      $display("FAIL multi_err got=%b want=0", bus.digit_err[2]); end
  endtask

  task automatic test_reset_mid();
    bus.seg_in = ~7'h7F;
    bus.dig_en = ~4'b1000;
    repeat (S / 2 + 3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.value !== 16'h0 || bus.digit_valid !== 4'h0 || bus.digit_err !== 4'h0)
    begin failures++;
      $display("FAIL midreset_clear got=%h/%b/%b want=0", bus.value, bus.digit_valid,
               bus.digit_err);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    play(7'h7F, 4'b1000, S + 4);
    flush();
    checks++; if (bus.value !== 16'h8000) begin failures++;
      $display("FAIL midreset_value got=%h want=8000", bus.value); end
    checks++; if (bus.digit_valid !== 4'b1000) begin failures++;
      $display("FAIL midreset_valid got=%b want=1000", bus.digit_valid); end
  endtask

  task automatic test_random();
    logic [6:0] pat, ppat;
    logic [3:0] dig, pdig;
    ppat = '0; pdig = '0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 12; k++) begin
        pat = ($urandom_range(0, 9) < 8) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
        dig = ($urandom_range(0, 9) < 8) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
        if (pat == ppat && dig == pdig) pat = pat ^ 7'h40;
        play(pat, dig, $urandom_range(S - 3, S + 5));
        ppat = pat; pdig = dig;
      end
      flush();
      ppat = '0; pdig = '0;
      checks++; if (bus.value !== m_value) begin failures++;
        $display("FAIL rand%0d_value got=%h want=%h", b, bus.value, m_value); end
      checks++; if (bus.digit_valid !== m_valid) begin failures++;
        $display("FAIL rand%0d_valid got=%b want=%b", b, bus.digit_valid, m_valid); end
      checks++; if (bus.digit_err !== m_err) begin failures++;
        $display("FAIL rand%0d_err got=%b want=%b", b, bus.digit_err, m_err); end
      checks++; if (frames_seen !== m_frames) begin failures++;
        $display("FAIL rand%0d_frames got=%0d want=%0d", b, frames_seen, m_frames); end
`ifdef SEG7_DECODE_ERR_CNT_EN
      checks++; if (int'(bus.err_count) !== m_errcnt) begin failures++;
        $display("FAIL rand%0d_errcnt got=%0d want=%0d", b, bus.err_count, m_errcnt); end
`endif
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.seg_in = '1;
    bus.dig_en = '1;
    m_frames   = 0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_scan();
    test_toggle();
    test_blank();
    test_multi();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
